// File: rtl/power_sbox_target.sv
// power_sbox_target
//   Power-analysis target for the iCE40 side-channel examples. A 32-bit LFSR
//   supplies plaintext; NUM_BYTES AES S-box lanes run NUM_ROUNDS key-mixed
//   passes per operation, either free-running (AUTO_RUN = 1) or on a start
//   request (AUTO_RUN = 0). Each lane LSB feeds a chain of unity LUT cells
//   that exists only to add switching activity around the S-box result.
//
// Ports
//   ICE_CLK      clock
//   resetn       synchronous, active-low reset
//   start        one-cycle request, used only when AUTO_RUN = 0
//   dec          1 = inverse S-box, 0 = forward; latched when an operation starts
//   key_in       round key (8*NUM_BYTES bits); latched when an operation starts
//   busy         high in every state except IDLE
//   trigger      scope trigger, high in LOAD and ROUND
//   done         registered one-cycle pulse in the first IDLE cycle after the
//                final round write
//   text_q       text register
//   lfsr_q       LFSR state
//   amp_out      OR of all amplifier chain ends (follows text_q combinationally)
//   dbg_state_o  current FSM state encoding
//
// Request semantics: start is a level sampled on the rising edge of ICE_CLK
// only while the FSM is in IDLE; there is no ready/acknowledge. A request seen
// in any other state is dropped, never queued. busy = 0 means the next start
// will be taken, including the cycle in which done is high.

// Unity LUT4 cell with SB_LUT4 semantics: lut_o = LUT_INIT[{i3, i2, i1, i0}].
module power_sbox_lut4 #(
  parameter logic [15:0] LUT_INIT = 16'h0002
) (
  input  logic [3:0] lut_i,
  output logic       lut_o
);
  assign lut_o = LUT_INIT[lut_i];
endmodule

// AES S-box: forward = affine(inv(x)), inverse = inv(inv_affine(x)),
// with inv() the multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1.
module aes_sbox_lut (
  input  logic [7:0] byte_in,
  input  logic       dec,
  output logic [7:0] byte_out
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      bb = {1'b0, bb[7:1]};
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^
           {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    byte_out = 8'h00;
    if (dec) byte_out = gf_inv(inv_affine(byte_in));
    else     byte_out = fwd_affine(gf_inv(byte_in));
  end
endmodule

module power_sbox_target #(
  parameter int          NUM_BYTES   = 4,
  parameter int          NUM_ROUNDS  = 4,
  parameter int          IDLE_CYCLES = 10,
  parameter int          AMP_LEN     = 48,
  parameter int          AUTO_RUN    = 1,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1ACE1
) (
  input  logic                     ICE_CLK,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     dec,
  input  logic [8*NUM_BYTES-1:0]   key_in,
  output logic                     busy,
  output logic                     trigger,
  output logic                     done,
  output logic [8*NUM_BYTES-1:0]   text_q,
  output logic [31:0]              lfsr_q,
  output logic                     amp_out,
  output logic [2:0]               dbg_state_o
);
  localparam int         W          = 8 * NUM_BYTES;
  localparam logic [7:0] IDLE_LAST  = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ADVANCE = 3'd2,
    ST_LOAD    = 3'd3,
    ST_ROUND   = 3'd4
  } state_t;

  state_t         state_q;
  logic [7:0]     dwell_q;
  logic [3:0]     round_q;
  logic [W-1:0]   key_q;
  logic           dec_q;
  logic           done_q;

  logic [31:0]    lfsr_d;
  logic [W-1:0]   lane_src;
  logic [W-1:0]   lane_in;
  logic [W-1:0]   text_d;
  logic           go;
  logic [3:0]     round_inc;

  // Taps 32, 22, 2, 1 (maximal length; the all-zero state is unreachable).
  assign lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

  // LOAD mixes fresh plaintext; every later pass feeds the text back.
  assign lane_src  = (state_q == ST_LOAD) ? lfsr_q[W-1:0] : text_q;
  assign lane_in   = lane_src ^ key_q;
  assign round_inc = round_q + 4'd1;
  assign go        = (AUTO_RUN != 0) ? (dwell_q == IDLE_LAST) : start;

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    aes_sbox_lut u_sbox (
      .byte_in  (lane_in[8*i +: 8]),
      .dec      (dec_q),
      .byte_out (text_d[8*i +: 8])
    );
  end

  always_ff @(posedge ICE_CLK) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      dwell_q <= 8'd0;
      round_q <= 4'd0;
      lfsr_q  <= LFSR_SEED;
      text_q  <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_CLEAR;
            dwell_q <= 8'd0;
            key_q   <= key_in;
            dec_q   <= dec;
          end else if (AUTO_RUN != 0) begin
            dwell_q <= dwell_q + 8'd1;
          end
        end
        ST_CLEAR: begin
          text_q  <= '0;
          state_q <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          lfsr_q  <= lfsr_d;
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          text_q  <= text_d;
          round_q <= 4'd1;
          if (NUM_ROUNDS == 1) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          text_q  <= text_d;
          round_q <= round_inc;
          if (round_inc == ROUND_LAST) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign trigger     = (state_q == ST_LOAD) || (state_q == ST_ROUND);
  assign done        = done_q;
  assign dbg_state_o = state_q;

  // Amplifier: each lane LSB ripples through AMP_LEN buffer-configured LUTs.
  // The chains compute nothing; keep stops synthesis from collapsing them.
  logic [NUM_BYTES-1:0] amp_end;

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_amp
    (* keep *) logic [AMP_LEN:0] amp_chain;
    assign amp_chain[0] = text_q[8*i];
    for (genvar j = 0; j < AMP_LEN; j++) begin : g_cell
      power_sbox_lut4 #(
        .LUT_INIT (16'h0002)
      ) u_lut (
        .lut_i ({3'b000, amp_chain[j]}),
        .lut_o (amp_chain[j+1])
      );
    end
    assign amp_end[i] = amp_chain[AMP_LEN];
  end

  assign amp_out = |amp_end;
endmodule

// File: tb/tb_power_sbox_target.sv
// tb_power_sbox_target
//   Three instances of power_sbox_target: a manual 4-lane/4-round one, a
//   free-running default one, and a manual 2-lane/1-round one. Expected values
//   come from an AES S-box table built by the generator-3 log method and a
//   software LFSR.
module tb_power_sbox_target;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // manual instance
  logic        rst_m, start_m, dec_m;
  logic [31:0] key_m;
  logic        busy_m, trig_m, done_m, amp_m;
  logic [31:0] text_m, lfsr_m;
  logic [2:0]  st_m;
  // auto instance
  logic        rst_a, start_a, dec_a;
  logic [31:0] key_a;
  logic        busy_a, trig_a, done_a, amp_a;
  logic [31:0] text_a, lfsr_a;
  logic [2:0]  st_a;
  // small instance
  logic        rst_s, start_s, dec_s;
  logic [15:0] key_s;
  logic        busy_s, trig_s, done_s, amp_s;
  logic [15:0] text_s;
  logic [31:0] lfsr_s;
  logic [2:0]  st_s;

  power_sbox_target #(.AUTO_RUN(0)) u_man (
    .ICE_CLK(clk), .resetn(rst_m), .start(start_m), .dec(dec_m), .key_in(key_m),
    .busy(busy_m), .trigger(trig_m), .done(done_m), .text_q(text_m),
    .lfsr_q(lfsr_m), .amp_out(amp_m), .dbg_state_o(st_m)
  );

  power_sbox_target #(.AUTO_RUN(1)) u_auto (
    .ICE_CLK(clk), .resetn(rst_a), .start(start_a), .dec(dec_a), .key_in(key_a),
    .busy(busy_a), .trigger(trig_a), .done(done_a), .text_q(text_a),
    .lfsr_q(lfsr_a), .amp_out(amp_a), .dbg_state_o(st_a)
  );

  power_sbox_target #(.NUM_BYTES(2), .NUM_ROUNDS(1), .AUTO_RUN(0)) u_small (
    .ICE_CLK(clk), .resetn(rst_s), .start(start_s), .dec(dec_s), .key_in(key_s),
    .busy(busy_s), .trigger(trig_s), .done(done_s), .text_q(text_s),
    .lfsr_q(lfsr_s), .amp_out(amp_s), .dbg_state_o(st_s)
  );

  // ---------------- reference model ----------------
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse in step,
  // so q is always p^-1; then apply the AES affine map.
  task automatic build_tables();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[8'(i)]] = 8'(i);
  endtask

  function automatic logic [31:0] sbox_word(input logic [31:0] x, input logic d, input int nb);
    logic [31:0] r;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < nb; i++) begin
      b = x[8*i +: 8];
      r[8*i +: 8] = d ? isb[b] : sb[b];
    end
    return r;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mlfsr_m, mlfsr_a, mlfsr_s;

  // One manual operation on u_man, entered and left in an IDLE cycle (the
  // exit cycle is the done cycle). Inputs are scrambled after the start edge.
  task automatic run_op(input logic d, input logic [31:0] k, output logic [31:0] got_load);
    logic [31:0] exp_t;
    start_m = 1'b1; dec_m = d; key_m = k;
    step();                                   // CLEAR
    start_m = 1'b0; key_m = $urandom; dec_m = 1'($urandom);
    chk("clear_busy", busy_m, 1);
    chk("clear_trig", trig_m, 0);
    chk("clear_done", done_m, 0);
    step();                                   // ADVANCE
    chk("text_cleared", text_m, 0);
    mlfsr_m = lfsr_next(mlfsr_m);
    step();                                   // LOAD
    chk("lfsr", lfsr_m, mlfsr_m);
    chk("lfsr_nonzero", {31'b0, lfsr_m != 32'h0}, 1);
    chk("load_trig", trig_m, 1);
    step();                                   // first ROUND
    exp_q.push_back(sbox_word(mlfsr_m ^ k, d, 4));
    for (int r = 2; r <= 4; r++) exp_q.push_back(sbox_word(exp_q[$] ^ k, d, 4));
    got_load = text_m;
    exp_t = exp_q.pop_front();
    chk("load_text", text_m, exp_t);
    for (int r = 2; r <= 4; r++) begin
      step();
      exp_t = exp_q.pop_front();
      chk("round_text", text_m, exp_t);
    end
    chk("done_pulse", done_m, 1);
    chk("done_not_busy", busy_m, 0);
    chk("amp", amp_m, exp_t[0] | exp_t[8] | exp_t[16] | exp_t[24]);
  endtask

  typedef struct {
    logic        dec;
    logic [31:0] key;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, exp_t;
    int n_done, done_at;

    vecs[0] = '{1'b1, 32'h59C359C3, 32'h52525252};
    vecs[1] = '{1'b0, 32'h59C359C3, 32'h63636363};
    vecs[2] = '{1'b0, 32'h00000000, 32'hCB2ECB2E};
    vecs[3] = '{1'b1, 32'h00000000, 32'h15331533};
    build_tables();

    rst_m = 0; start_m = 0; dec_m = 0; key_m = '0;
    rst_a = 0; start_a = 0; dec_a = 0; key_a = '0;
    rst_s = 0; start_s = 0; dec_s = 0; key_s = '0;
    repeat (3) step();

    // reset values
    chk("rst_busy", busy_m, 0);
    chk("rst_trig", trig_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_text", text_m, 0);
    chk("rst_lfsr", lfsr_m, 32'hACE1ACE1);
    chk("rst_amp", amp_m, 0);
    chk("rst_state", st_m, 0);
    chk("rst_lfsr_auto", lfsr_a, 32'hACE1ACE1);
    chk("rst_busy_auto", busy_a, 0);

    // table-driven: each vector right after reset (first LFSR value 0x59C359C3)
    foreach (vecs[i]) begin
      rst_m = 0; step(); step(); rst_m = 1;
      mlfsr_m = 32'hACE1ACE1;
      run_op(vecs[i].dec, vecs[i].key, got);
      chk("vec_load", got, vecs[i].exp_load);
    end

    // randomised back-to-back operations against the model
    rst_m = 0; step(); rst_m = 1;
    mlfsr_m = 32'hACE1ACE1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 1)) step();
      run_op(1'($urandom), $urandom, got);
    end

    // start during CLEAR and ROUND is dropped: exactly one done
    step(); step();
    start_m = 1; dec_m = 0; key_m = 32'h0F1E2D3C;
    step();                                   // CLEAR
    step();                                   // ADVANCE (start was high in CLEAR)
    start_m = 0;
    mlfsr_m = lfsr_next(mlfsr_m);
    step();                                   // LOAD
    step();                                   // ROUND
    start_m = 1;
    step();                                   // ROUND
    start_m = 0;
    n_done = 0; done_at = -1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (done_m) begin n_done++; if (done_at < 0) done_at = c; end
    end
    chk("ignored_one_done", n_done, 1);
    chk("ignored_done_pos", done_at, 1);
    chk("ignored_idle", busy_m, 0);
    chk("ignored_lfsr", lfsr_m, mlfsr_m);

    // reset asserted in a ROUND cycle
    start_m = 1; key_m = $urandom;
    step(); start_m = 0;
    repeat (4) step();                        // now in ROUND
    chk("mid_rst_in_round", trig_m, 1);
    rst_m = 0;
    step();
    chk("mid_rst_text", text_m, 0);
    chk("mid_rst_lfsr", lfsr_m, 32'hACE1ACE1);
    chk("mid_rst_done", done_m, 0);
    chk("mid_rst_busy", busy_m, 0);
    rst_m = 1;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin step(); if (done_m) n_done++; end
    chk("mid_rst_no_done", n_done, 0);

    // start and reset together: reset wins
    rst_m = 0; start_m = 1;
    step();
    rst_m = 1; start_m = 0;
    chk("rst_wins_busy", busy_m, 0);
    step();
    chk("rst_wins_still_idle", busy_m, 0);

    // free-running defaults: 16-cycle period
    key_a = $urandom; dec_a = 0;
    mlfsr_a = 32'hACE1ACE1;
    rst_a = 1;                                // this cycle is period count 0
    for (int c = 0; c < 48; c++) begin
      int p;
      p = c % 16;
      chk("auto_busy", busy_a, (p >= 10) ? 1 : 0);
      chk("auto_trig", trig_a, (p >= 12) ? 1 : 0);
      chk("auto_done", done_a, (p == 0 && c >= 16) ? 1 : 0);
      if (p == 11) chk("auto_text_clear", text_a, 0);
      if (p == 12) begin
        mlfsr_a = lfsr_next(mlfsr_a);
        chk("auto_lfsr", lfsr_a, mlfsr_a);
      end
      if (p == 13) chk("auto_load_text", text_a, sbox_word(mlfsr_a ^ key_a, 1'b0, 4));
      start_a = 1'($urandom);
      step();
    end

    // 2 lanes, 1 round: LOAD returns straight to IDLE
    rst_s = 1;
    mlfsr_s = 32'hACE1ACE1;
    step();
    for (int n = 0; n < 6; n++) begin
      logic d;
      logic [15:0] k;
      d = 1'($urandom);
      k = 16'($urandom);
      start_s = 1; dec_s = d; key_s = k;
      step();                                 // CLEAR
      start_s = 0; key_s = 16'($urandom);
      step();                                 // ADVANCE
      mlfsr_s = lfsr_next(mlfsr_s);
      step();                                 // LOAD
      chk("small_trig", trig_s, 1);
      chk("small_lfsr", lfsr_s, mlfsr_s);
      step();                                 // start-edge + 4
      exp_t = sbox_word(mlfsr_s ^ {16'h0, k}, d, 2);
      chk("small_done", done_s, 1);
      chk("small_idle", busy_s, 0);
      chk("small_text", {16'h0, text_s}, exp_t);
      chk("small_amp", amp_s, exp_t[0] | exp_t[8]);
    end
    step();
    chk("small_done_clears", done_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
